// File: rtl/skewed_adder_pkg.sv
// Shared sizing helpers for the chunk-sliced skewed adder.
package skewed_adder_pkg;

  // Integer ceiling division, used to size the chunk count.
  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

  function automatic int unsigned min_u(input int unsigned x, input int unsigned y);
    return (x < y) ? x : y;
  endfunction

  // Number of chunks a WIDTH-bit word splits into.
  function automatic int unsigned n_chunks(input int unsigned width, input int unsigned chunk);
    return ceil_div(width, chunk);
  endfunction

  // Width of chunk idx; only the top chunk may be narrower than CHUNK.
  function automatic int unsigned chunk_w(input int unsigned width, input int unsigned chunk,
                                          input int unsigned idx);
    return min_u(chunk, width - idx * chunk);
  endfunction

endpackage

// File: rtl/skewed_adder_stage.sv
// One chunk of the skewed adder: registered W-bit add with carry/valid/mode forwarding.
module skewed_adder_stage
  import skewed_adder_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         v_in,
  input  logic         m_in,
  input  logic         c_in,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         v_out,
  output logic         m_out,
  output logic         c_out,
  output logic [W-1:0] s
);

  localparam int unsigned WX = W + 1;

  logic [W-1:0]  bb_c;
  logic [WX-1:0] res_c;
  logic [W-1:0]  sum_d,   sum_q;
  logic          carry_d, carry_q;
  logic          valid_d, valid_q;
  logic          sub_d,   sub_q;

  // Chunk arithmetic; carry-in only counts for a valid slot so nothing leaks across slots.
  always_comb begin
    bb_c    = m_in ? ~b : b;
    res_c   = {1'b0, a} + {1'b0, bb_c} + WX'(v_in & c_in);
    sum_d   = res_c[W-1:0];
    carry_d = v_in & res_c[W];
    valid_d = v_in;
    sub_d   = m_in;
  end

  // Stage registers; en low freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      sub_q   <= 1'b0;
    end else if (en) begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      sub_q   <= sub_d;
    end
  end

  assign s     = sum_q;
  assign c_out = carry_q;
  assign v_out = valid_q;
  assign m_out = sub_q;

endmodule

// File: rtl/skewed_adder.sv
// Pipelined adder/subtractor on chunk-skewed operands; result stays skewed.
module skewed_adder
  import skewed_adder_pkg::*;
#(
  parameter  int unsigned WIDTH  = 32,
  parameter  int unsigned CHUNK  = 8,
  localparam int unsigned NCHUNK = n_chunks(WIDTH, CHUNK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic              sub,
  input  logic              cin,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  sum,
  output logic [NCHUNK-1:0] out_valid,
  output logic              cout
);

  // Control chain: index i feeds stage i, index i+1 is stage i's registered output.
  logic [NCHUNK:0] v_ch;
  logic [NCHUNK:0] m_ch;
  logic [NCHUNK:0] c_ch;
  logic            unused_sub_last;

  // Stage 0 control; subtract forces carry-in to 1 for two's complement.
  assign v_ch[0] = in_valid;
  assign m_ch[0] = sub;
  assign c_ch[0] = sub | cin;

  for (genvar i = 0; i < NCHUNK; i++) begin : g_stage
    localparam int unsigned WI = chunk_w(WIDTH, CHUNK, i);
    localparam int unsigned LO = i * CHUNK;

    skewed_adder_stage #(
      .W(WI)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .v_in  (v_ch[i]),
      .m_in  (m_ch[i]),
      .c_in  (c_ch[i]),
      .a     (a[LO +: WI]),
      .b     (b[LO +: WI]),
      .v_out (v_ch[i+1]),
      .m_out (m_ch[i+1]),
      .c_out (c_ch[i+1]),
      .s     (sum[LO +: WI])
    );
  end

  assign out_valid       = v_ch[NCHUNK:1];
  assign cout            = c_ch[NCHUNK];
  assign unused_sub_last = m_ch[NCHUNK];

endmodule

// File: tb/tb_skewed_adder.sv
// Scoreboard bench: a 16/4 instance and a ragged 10/4 instance driven in lockstep.
module tb_skewed_adder;

  typedef struct packed {
    logic        v;
    logic        m;
    logic        c;
    logic [15:0] a;
    logic [15:0] b;
  } slot_t;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
  } exp_t;

  logic        clk, rst, en;
  logic        iv0, sb0, ci0, iv1, sb1, ci1;
  logic [15:0] a0, b0, sum0;
  logic [9:0]  a1, b1, sum1;
  logic [3:0]  ov0;
  logic [2:0]  ov1;
  logic        co0, co1;

  int n_checks = 0;
  int n_errors = 0;

  slot_t       shist [2][4];
  logic [15:0] ohs   [2][4];
  logic [3:0]  ohv   [2][4];
  exp_t        q0[$];
  exp_t        q1[$];

  skewed_adder #(.WIDTH(16), .CHUNK(4)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv0), .sub(sb0), .cin(ci0),
    .a(a0), .b(b0), .sum(sum0), .out_valid(ov0), .cout(co0)
  );

  skewed_adder #(.WIDTH(10), .CHUNK(4)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv1), .sub(sb1), .cin(ci1),
    .a(a1), .b(b1), .sum(sum1), .out_valid(ov1), .cout(co1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic m, input logic c,
                                 input logic [15:0] a, input logic [15:0] b);
    logic [31:0] mask, ext, bb;
    exp_t r;
    mask = (32'd1 << w) - 32'd1;
    bb   = m ? {16'h0, ~b} : {16'h0, b};
    ext  = ({16'h0, a} & mask) + (bb & mask) + {31'd0, (m | c)};
    r.s  = 16'(ext & mask);
    r.co = ext[w];
    return r;
  endfunction

  function automatic logic [15:0] skew(input int l, input bit sel_b);
    logic [15:0] r = '0;
    for (int i = 0; i < ((l == 0) ? 4 : 3); i++)
      r[i*4 +: 4] = sel_b ? shist[l][i].b[i*4 +: 4] : shist[l][i].a[i*4 +: 4];
    return r;
  endfunction

  // Present a new slot on lane l (taken on the next enabled cycle).
  task automatic put(input int l, input logic v, input logic m, input logic c,
                     input logic [15:0] a, input logic [15:0] b);
    shist[l][0] = '{v: v, m: m, c: c, a: a, b: b};
    if (v) begin
      if (l == 0) q0.push_back(model(16, m, c, a, b));
      else        q1.push_back(model(10, m, c, a, b));
    end
  endtask

  task automatic clear_model();
    for (int l = 0; l < 2; l++)
      for (int k = 0; k < 4; k++) begin
        shist[l][k] = '0;
        ohs[l][k]   = '0;
        ohv[l][k]   = '0;
      end
    q0.delete();
    q1.delete();
  endtask

  // One clock: drive skewed inputs, then sample, deskew and score completed slots.
  task automatic cyc(input logic en_v);
    logic [15:0] sa0, sb0v, sa1, sb1v;
    sa0  = skew(0, 1'b0);
    sb0v = skew(0, 1'b1);
    sa1  = skew(1, 1'b0);
    sb1v = skew(1, 1'b1);
    a0 = sa0; b0 = sb0v; a1 = sa1[9:0]; b1 = sb1v[9:0];
    iv0 = shist[0][0].v; sb0 = shist[0][0].m; ci0 = shist[0][0].c;
    iv1 = shist[1][0].v; sb1 = shist[1][0].m; ci1 = shist[1][0].c;
    en = en_v;
    @(posedge clk);
    #1;
    if (en_v) begin
      for (int l = 0; l < 2; l++) begin
        int          n;
        logic [15:0] d;
        logic [3:0]  vm;
        logic        co;
        exp_t        e;
        n  = (l == 0) ? 4 : 3;
        co = (l == 0) ? co0 : co1;
        for (int k = 3; k > 0; k--) begin
          ohs[l][k] = ohs[l][k-1];
          ohv[l][k] = ohv[l][k-1];
        end
        ohs[l][0] = (l == 0) ? sum0 : {6'h0, sum1};
        ohv[l][0] = (l == 0) ? ov0 : {1'b0, ov1};
        if (ohv[l][0][n-1]) begin
          d  = '0;
          vm = '0;
          for (int i = 0; i < n; i++) begin
            d[i*4 +: 4] = ohs[l][n-1-i][i*4 +: 4];
            vm[i]       = ohv[l][n-1-i][i];
          end
          check_eq($sformatf("vld_chain%0d", l), 32'(vm), (32'd1 << n) - 32'd1);
          if ((l == 0 && q0.size() == 0) || (l == 1 && q1.size() == 0)) begin
            check_eq($sformatf("q%0d_underflow", l), 32'd0, 32'd1);
          end else begin
            e = (l == 0) ? q0.pop_front() : q1.pop_front();
            check_eq($sformatf("sum%0d", l), 32'(d), 32'(e.s));
            check_eq($sformatf("cout%0d", l), 32'(co), 32'(e.co));
          end
        end
        for (int k = 3; k > 0; k--) shist[l][k] = shist[l][k-1];
        shist[l][0] = '0;
      end
    end
  endtask

  initial begin
    logic [15:0] ev;
    logic [15:0] ra, rb;
    clear_model();
    rst = 1'b0; en = 1'b0;
    iv0 = 0; sb0 = 0; ci0 = 0; iv1 = 0; sb1 = 0; ci1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    #12;
    check_eq("rst_sum0", 32'(sum0), 32'd0);
    check_eq("rst_ov0",  32'(ov0),  32'd0);
    check_eq("rst_co0",  32'(co0),  32'd0);
    check_eq("rst_ov1",  32'(ov1),  32'd0);
    rst = 1'b1;
    cyc(1'b1);

    // Ripple through chunks 0,1 into 2.
    ev = 16'h0100;
    put(0, 1, 0, 0, 16'h00FF, 16'h0001);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1);
      check_eq($sformatf("ripple_ov_c%0d", k), 32'(ov0), 32'd1 << (k - 1));
      check_eq($sformatf("ripple_chunk%0d", k - 1), 32'(sum0[(k-1)*4 +: 4]), 32'(ev[(k-1)*4 +: 4]));
    end

    // Subtract with and without borrow.
    put(0, 1, 1, 0, 16'h0000, 16'h0001); cyc(1'b1);
    put(0, 1, 1, 0, 16'h1234, 16'h0234); cyc(1'b1);
    repeat (5) cyc(1'b1);

    // Back-to-back with a bubble carrying all-ones operands.
    put(0, 1, 0, 0, 16'hFFFF, 16'h0001); cyc(1'b1);
    put(0, 0, 0, 1, 16'hFFFF, 16'hFFFF); cyc(1'b1);
    put(0, 1, 0, 0, 16'h0001, 16'h0001); cyc(1'b1);
    cyc(1'b1);
    check_eq("bubble_ov", 32'(ov0), 32'b1010);
    repeat (4) cyc(1'b1);

    // Stall for 3 cycles after two chunks.
    put(0, 1, 0, 0, 16'h7FFF, 16'h0001);
    cyc(1'b1); cyc(1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0);
      check_eq($sformatf("stall_ov%0d", k), 32'(ov0), 32'b0010);
      check_eq($sformatf("stall_sum%0d", k), 32'(sum0), 32'h0000);
    end
    cyc(1'b1);
    check_eq("stall_resume_ov", 32'(ov0), 32'b0100);
    cyc(1'b1);
    check_eq("stall_done_ov", 32'(ov0), 32'b1000);
    repeat (2) cyc(1'b1);

    // Asynchronous reset with two slots in flight.
    put(0, 1, 0, 1, 16'h1111, 16'h2222); cyc(1'b1);
    put(0, 1, 1, 0, 16'h5555, 16'h0F0F); cyc(1'b1);
    #2 rst = 1'b0;
    #1;
    check_eq("midrst_sum0", 32'(sum0), 32'd0);
    check_eq("midrst_ov0",  32'(ov0),  32'd0);
    check_eq("midrst_co0",  32'(co0),  32'd0);
    clear_model();
    #2 rst = 1'b1;
    put(0, 1, 0, 0, 16'h0003, 16'h0004);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1);
      check_eq($sformatf("postrst_ov_c%0d", k), 32'(ov0), 32'd1 << (k - 1));
    end
    cyc(1'b1);

    // Ragged 10-bit lane (chunks 4,4,2).
    put(1, 1, 0, 0, 16'h03FF, 16'h0001);
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    check_eq("rag_ov",   32'(ov1), 32'b100);
    check_eq("rag_cout", 32'(co1), 32'd1);
    put(1, 1, 0, 0, 16'h01FF, 16'h0001);
    repeat (4) cyc(1'b1);

    // Random traffic on both lanes with occasional stalls.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 5) == 0) cyc(1'b0);
      for (int l = 0; l < 2; l++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        put(l, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), ra, rb);
      end
      cyc(1'b1);
    end
    repeat (6) cyc(1'b1);
    check_eq("q0_drained", 32'(q0.size()), 32'd0);
    check_eq("q1_drained", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/skewed_adder.md
Name: skewed_adder

Overview:
- Chunk-sliced pipelined adder/subtractor that consumes operands already skewed by the upstream chunk-skew stage. In that format, chunk i of a word arrives i cycles after chunk 0.
- Stage i adds chunk i and forwards its registered carry to stage i+1, which sees it in the next cycle, exactly when the matching chunk arrives.
- Output stays in skewed format for the downstream deskew stage or the next skewed arithmetic stage.

Parameters:
- WIDTH, 32, total operand width in bits (>=1).
- CHUNK, 8, bits per chunk (>=1).
- NCHUNK (localparam) = ceil_division(WIDTH, CHUNK).
- Chunk i width W_i = min(CHUNK, WIDTH - i*CHUNK). Only the last chunk may be narrower.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset; 0 = reset asserted.
- en  in  1  global advance; 0 freezes every register.
- in_valid  in  1  slot valid, aligned with chunk 0 of a and b.
- sub  in  1  1 = compute a-b, 0 = a+b; aligned with chunk 0.
- cin  in  1  carry-in for add mode; ignored when sub=1. Aligned with chunk 0.
- a  in  WIDTH  skewed operand A; chunk i at bits [i*CHUNK +: W_i].
- b  in  WIDTH  skewed operand B, same layout as a.
- sum  out  WIDTH  skewed result, same layout as a.
- out_valid  out  NCHUNK  bit i = sum chunk i currently holds a valid slot.
- cout  out  1  carry out of the MSB, aligned with the last sum chunk. In sub mode, 1 = no borrow.

Behaviour:
- Reset (rst=0, async): clear all sum chunks, carry regs, valid regs and sub regs to 0. Outputs read sum=0, out_valid=0, cout=0 immediately and stay there until the first enabled edge after rst=1.
- All sequential updates happen only on rising clk edges with rst=1 and en=1. With en=0, every register holds its value, outputs hold, and inputs are ignored.
- Per-stage control inputs:
  - Stage 0 control: v_in=in_valid, m_in=sub, c_in = sub ? 1 : cin.
  - Stage i>0 control: v_in=valid_q[i-1], m_in=sub_q[i-1], c_in=carry_q[i-1]. These registers were written on the previous edge by the same slot.
- Stage i per enabled edge:
  - bb = m_in ? ~b_i : b_i.
  - {c, s} = a_i + bb + (v_in ? c_in : 0), computed at W_i+1 bits.
  - sum_q[i] <= s.
  - carry_q[i] <= v_in ? c : 0.
  - valid_q[i] <= v_in.
  - sub_q[i] <= m_in.
- Invalid slots still produce sum bits, but with valid low and carry forced to 0. No carry leaks between slots.
- Latency: a slot presented at cycle k (chunk i at cycle k+i) shows sum chunk i at cycle k+i+1. The full result is complete NCHUNK cycles after chunk 0.
- Throughput: one slot per enabled cycle. Back-to-back slots must not interfere.
- Output mapping:
  - out_valid[i] = valid_q[i].
  - cout = carry_q[NCHUNK-1]. It is the carry out of bit W_last of the last chunk, not bit CHUNK.
- NCHUNK=1 degenerates to a single registered adder with latency 1.
- Mid-operation reset discards every in-flight slot. The first slot after release behaves as if the pipeline were freshly empty.
- Bits outside [0, WIDTH) do not exist. Last-chunk arithmetic uses exactly W_last bits.

Decomposition:
- ceil_division and min come from the codebase's shared math package. The same package holds NCHUNK/W_i helpers if they are not already there.
- No new typedefs are needed.
- One natural sub-module: skewed_adder_stage.
  - Parameter W.
  - Ports: clk, rst, en, v_in, m_in, c_in, a, b, v_out, m_out, c_out, s.
  - The top level instantiates NCHUNK of these in a generate loop, chaining v/m/c outputs to the next stage's inputs.

Test Plan:
- Setup: WIDTH=16, CHUNK=4. Drive each slot through a bench-side skewer and deskew the outputs.
- Add with ripple: a=0x00FF, b=0x0001, cin=0, sub=0 at cycle 0 -> sum chunks 0,0,1,0 at cycles 1,2,3,4 (deskewed 0x0100), cout=0, out_valid[i] high at cycle i+1 only.
- Subtract: a=0x0000, b=0x0001, sub=1 -> deskewed 0xFFFF, cout=0 (borrow). Then a=0x1234, b=0x0234 -> 0x1000, cout=1.
- Back-to-back with bubble, 3 slots in consecutive cycles:
  - slot 1: 0xFFFF+0x0001 -> 0x0000, cout=1.
  - slot 2: invalid (in_valid=0), with a=0xFFFF, b=0xFFFF.
  - slot 3: 0x0001+0x0001 -> 0x0002, cout=0.
  - Required: slot 3 result exact, i.e. no carry from slot 1 or the bubble; out_valid pattern shows a one-slot hole.
- Stall: hold en=0 for 3 cycles while slot 0x7FFF+0x0001 is half-way through (after 2 chunks) -> outputs frozen during the stall. Completes as 0x8000, cout=0, with latency extended by exactly 3 cycles.
- Reset mid-flight: assert rst=0 asynchronously between edges while 2 slots are in flight -> sum, out_valid and cout go to 0 immediately. After release, a fresh 0x0003+0x0004 yields 0x0007 with normal latency.
- Ragged width: WIDTH=10, CHUNK=4 (chunks 4,4,2). 0x3FF+0x001 -> 0x000, cout=1 at cycle 3. 0x1FF+0x001 -> 0x200, cout=0.
